// File: rtl/store_buffer.sv
// Byte serializer that turns one 8/16/32-bit store into little-endian byte writes on the 8-bit memory bus.
// Define STORE_BUF_ARB_EN to honour the bus arbiter handshake; otherwise the grant is assumed permanently held.
module store_buffer #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              store_req_i,
   input  logic [31:0]       store_addr_i,
   input  logic [DATA_W-1:0] store_data_i,
   input  logic [1:0]        store_size_i,
   input  logic              bus_grant_i,
   output logic              bus_req_o,
   output logic [ADDR_W-1:0] write_addr_o,
   output logic [7:0]        write_data_o,
   output logic              mem_wr_o,
   output logic              halt_req_o,
   output logic              busy_o,
   output logic              done_o
);

   typedef enum logic [1:0] {IDLE, REQ, WR, FIN} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   base_addr;
   logic [DATA_W-1:0]   data_q;
   logic [1:0]          last_idx;
   logic [1:0]          byte_idx;
   logic [1:0]          next_idx;
   logic                grant;
   logic                unused_addr;

`ifdef STORE_BUF_ARB_EN
   localparam logic ARB_EN = 1'b1;
   assign grant = bus_grant_i;
`else
   localparam logic ARB_EN = 1'b0;
   logic unused_grant;
   assign grant        = 1'b1;
   assign unused_grant = bus_grant_i;
`endif

   assign unused_addr = ^store_addr_i[31:ADDR_W];
   assign next_idx    = byte_idx + 2'd1;

   // byte_idx names the byte on the bus while mem_wr_o is high, and the
   // byte still waiting for a grant while it is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         base_addr    <= '0;
         data_q       <= '0;
         last_idx     <= '0;
         byte_idx     <= '0;
         bus_req_o    <= 1'b0;
         write_addr_o <= '0;
         write_data_o <= '0;
         mem_wr_o     <= 1'b0;
         halt_req_o   <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_o <= 1'b0;
               if (store_req_i) begin
                  base_addr  <= store_addr_i[ADDR_W-1:0];
                  data_q     <= store_data_i;
                  last_idx   <= (store_size_i == 2'd0) ? 2'd0 :
                                (store_size_i == 2'd1) ? 2'd1 : 2'd3;
                  byte_idx   <= 2'd0;
                  bus_req_o  <= ARB_EN;
                  halt_req_o <= 1'b1;
                  busy_o     <= 1'b1;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (grant) begin
                  write_addr_o <= base_addr;
                  write_data_o <= data_q[7:0];
                  mem_wr_o     <= 1'b1;
                  state        <= WR;
               end
            end
            WR: begin
               if (mem_wr_o) begin
                  if (byte_idx == last_idx) begin
                     mem_wr_o   <= 1'b0;
                     bus_req_o  <= 1'b0;
                     halt_req_o <= 1'b0;
                     busy_o     <= 1'b0;
                     done_o     <= 1'b1;
                     state      <= FIN;
                  end else begin
                     byte_idx <= next_idx;
                     mem_wr_o <= grant;
                     if (grant) begin
                        write_addr_o <= base_addr + ADDR_W'(next_idx);
                        write_data_o <= data_q[{next_idx, 3'b000} +: 8];
                     end
                  end
               end else if (grant) begin
                  write_addr_o <= base_addr + ADDR_W'(byte_idx);
                  write_data_o <= data_q[{byte_idx, 3'b000} +: 8];
                  mem_wr_o     <= 1'b1;
               end
            end
            FIN: begin
               done_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed cases plus randomized stores against a byte-launch model.
// Builds with or without STORE_BUF_ARB_EN; the model ignores the grant when arbitration is compiled out.
module tb_store_buffer;

`ifdef STORE_BUF_ARB_EN
   localparam bit ARB = 1'b1;
`else
   localparam bit ARB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        store_req_i;
   logic [31:0] store_addr_i;
   logic [31:0] store_data_i;
   logic [1:0]  store_size_i;
   logic        bus_grant_i;
   logic        bus_req_o;
   logic [16:0] write_addr_o;
   logic [7:0]  write_data_o;
   logic        mem_wr_o;
   logic        halt_req_o;
   logic        busy_o;
   logic        done_o;

   int checks   = 0;
   int failures = 0;

   // Model: a store needs N granted edges to launch its N bytes, and one more
   // edge to commit the last byte before the completion cycle.
   bit m_active, m_fin, m_wr;
   int m_launched, m_n, m_cur, m_base;
   logic [31:0] m_data;

   store_buffer dut (
      .clk(clk), .rst(rst), .store_req_i(store_req_i), .store_addr_i(store_addr_i),
      .store_data_i(store_data_i), .store_size_i(store_size_i), .bus_grant_i(bus_grant_i),
      .bus_req_o(bus_req_o), .write_addr_o(write_addr_o), .write_data_o(write_data_o),
      .mem_wr_o(mem_wr_o), .halt_req_o(halt_req_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_fin = 0; m_wr = 0;
      m_launched = 0; m_n = 0; m_cur = 0; m_base = 0; m_data = '0;
   endtask

   task automatic model_edge(input bit req, input bit g);
      bit eg;
      eg = ARB ? g : 1'b1;
      if (m_fin) begin
         m_fin = 0;
      end else if (!m_active) begin
         if (req) begin
            m_active   = 1;
            m_launched = 0;
            m_wr       = 0;
            m_base     = int'(store_addr_i & 32'h1FFFF);
            m_data     = store_data_i;
            m_n        = (store_size_i == 2'd0) ? 1 : (store_size_i == 2'd1) ? 2 : 4;
         end
      end else if (m_wr && m_launched == m_n) begin
         m_active = 0;
         m_wr     = 0;
         m_fin    = 1;
      end else if (m_launched < m_n && eg) begin
         m_wr  = 1;
         m_cur = m_launched;
         m_launched++;
      end else begin
         m_wr = 0;
      end
   endtask

   task automatic check_all(input string tag);
      check_output({tag, ".busy"}, busy_o, m_active);
      check_output({tag, ".halt"}, halt_req_o, m_active);
      check_output({tag, ".done"}, done_o, m_fin);
      check_output({tag, ".breq"}, bus_req_o, ARB && m_active);
      check_output({tag, ".wr"}, mem_wr_o, m_wr);
      if (m_wr) begin
         check_output({tag, ".addr"}, write_addr_o, (m_base + m_cur) & 32'h1FFFF);
         check_output({tag, ".data"}, write_data_o, (m_data >> (8 * m_cur)) & 32'hFF);
      end
   endtask

   // One clock: inputs set just after the falling edge, outputs checked at the next falling edge.
   task automatic apply_stimulus(input bit req, input bit g, input string tag);
      store_req_i = req;
      bus_grant_i = g;
      @(posedge clk);
      model_edge(req, g);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic run_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] size, input logic [31:0] gmask, input bit req_in_fin,
                            output int busy_cycles, output int writes);
      int n;
      busy_cycles  = 0;
      writes       = 0;
      store_addr_i = addr;
      store_data_i = data;
      store_size_i = size;
      apply_stimulus(1'b1, 1'b1, tag);
      busy_cycles += busy_o;
      n = 0;
      while (m_active || m_fin) begin
         if (n >= 100) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout observed=busy expected=idle", tag);
            return;
         end
         apply_stimulus(req_in_fin && m_fin, (n < 32) ? gmask[n] : 1'b1, tag);
         busy_cycles += busy_o;
         writes      += mem_wr_o;
         n++;
      end
      store_req_i = 1'b0;
   endtask

   initial begin
      int bc, wc;
      model_reset();
      rst = 1'b1; store_req_i = 0; store_addr_i = 0; store_data_i = 0; store_size_i = 0; bus_grant_i = 0;
      repeat (2) @(negedge clk);
      check_all("reset");
      check_output("reset.addr", write_addr_o, 0);
      check_output("reset.data", write_data_o, 0);
      rst = 1'b0;
      @(negedge clk);

      run_store("word", 32'h0000_0100, 32'hDEADBEEF, 2'd2, 32'hFFFF_FFFF, 1'b0, bc, wc);
      check_output("word.busy_cycles", bc, 5);
      check_output("word.writes", wc, 4);

      run_store("byte", 32'h0000_2345, 32'h0000_00A5, 2'd0, 32'hFFFF_FFFF, 1'b0, bc, wc);
      check_output("byte.busy_cycles", bc, 2);
      check_output("byte.writes", wc, 1);

      run_store("half_wrap", 32'h0001_FFFF, 32'h0000_1234, 2'd1, 32'hFFFF_FFFF, 1'b1, bc, wc);
      check_output("half_wrap.writes", wc, 2);

      run_store("stall", 32'h0000_0400, 32'h1122_3344, 2'd3, 32'hFFFF_FFF3, 1'b0, bc, wc);
      check_output("stall.busy_cycles", bc, ARB ? 7 : 5);
      check_output("stall.writes", wc, 4);

      run_store("nogrant", 32'h0000_0500, 32'hCAFEF00D, 2'd2, ARB ? 32'hFFFF_FFFF : 32'h0, 1'b0, bc, wc);
      check_output("nogrant.busy_cycles", bc, 5);

      // Reset while byte 2 of a word store is on the bus.
      store_addr_i = 32'h0000_0600; store_data_i = 32'h89AB_CDEF; store_size_i = 2'd2;
      apply_stimulus(1'b1, 1'b1, "rstmid");
      for (int i = 0; i < 20 && !(m_wr && m_cur == 2); i++) apply_stimulus(1'b0, 1'b1, "rstmid");
      check_output("rstmid.byte2", m_wr && m_cur == 2, 1);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("rstmid.async");
      check_output("rstmid.addr", write_addr_o, 0);
      check_output("rstmid.data", write_data_o, 0);
      @(negedge clk);
      check_all("rstmid.held");
      #1 rst = 1'b0;
      @(negedge clk);
      run_store("after_rst", 32'h0000_0700, 32'h5566_7788, 2'd2, 32'hFFFF_FFFF, 1'b0, bc, wc);
      check_output("after_rst.writes", wc, 4);

      for (int t = 0; t < 24; t++) begin
         run_store("rand", $urandom, $urandom, 2'($urandom_range(0, 3)), $urandom, 1'($urandom), bc, wc);
         check_output("rand.writes", wc, m_n);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-side byte serializer for the CPU's 8-bit memory bus. It accepts one store request per transaction from the memory stage: byte, half-word or word, 32-bit data, 32-bit address. It emits the store as consecutive little-endian byte writes on the 17-bit-address, 8-bit-data bus, asserting `mem_wr_o` for each byte. It sits beside the instruction-fetch byte reader, shares the same bus, and holds the pipeline through the halt controller until the store completes.

## Interface
Parameters:
- `ADDR_W`, default 17: memory bus address width; the low `ADDR_W` bits of `store_addr_i` are used.
- `DATA_W`, default 32: store data width. Fixed at 32; other values are unsupported.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst`, input, 1: reset; asynchronous, active-high.
- `store_req_i`, input, 1: store request; sampled only in IDLE.
- `store_addr_i`, input, 32: byte address of the lowest byte.
- `store_data_i`, input, 32: store data; byte k is `[8k+7:8k]`.
- `store_size_i`, input, 2: 0 = byte, 1 = half-word, 2 = word, 3 = word.
- `bus_grant_i`, input, 1: arbiter grant of the shared memory bus.
- `bus_req_o`, output, 1: bus request to the arbiter.
- `write_addr_o`, output, `ADDR_W`: byte address on the bus.
- `write_data_o`, output, 8: byte to write.
- `mem_wr_o`, output, 1: 1 = write the byte in this cycle, 0 = no write.
- `halt_req_o`, output, 1: stall request to the halt controller.
- `busy_o`, output, 1: transaction in progress.
- `done_o`, output, 1: one-cycle completion pulse.

## Operation
- States:
  - IDLE: waiting for a request.
  - REQ: requesting the bus.
  - WR: emitting bytes.
  - FIN: completion cycle.
- IDLE:
  - `store_req_i` = 1 → latch address (low `ADDR_W` bits), data and byte count N (1, 2 or 4).
  - Clear byte index k to 0; go to REQ.
- REQ:
  - `bus_req_o` = 1.
  - At the edge where `bus_grant_i` = 1 → drive byte 0 and go to WR.
- WR:
  - The byte driven this cycle is committed by memory at the cycle-ending edge.
  - At that edge with `bus_grant_i` = 1 and k < N-1 → drive byte k+1.
  - At that edge with `bus_grant_i` = 0 → `mem_wr_o` = 0 and k holds; the next byte is driven at the first edge where grant returns.
  - After byte N-1 is committed → go to FIN.
- FIN:
  - `done_o` = 1 and `bus_req_o` = 0; go to IDLE.
- Byte address is `base + k` modulo 2^`ADDR_W`, so 0x1FFFF is followed by 0x00000. Misaligned addresses are legal.
- `store_req_i` is ignored outside IDLE. A request coincident with `done_o` is not captured; the requester holds it until the next IDLE cycle.
- `halt_req_o` = `busy_o` = 1 in REQ and WR, 0 in IDLE and FIN.
- Reset mid-operation: the transaction is abandoned immediately with no further writes, and all state returns to IDLE.

## Timing
- All outputs are registered.
- Reset values:
  - `bus_req_o`, `mem_wr_o`, `halt_req_o`, `busy_o`, `done_o` = 0.
  - `write_addr_o` = 0, `write_data_o` = 0.
- Request captured at edge E0 → REQ from E0 onward.
- With grant high continuously:
  - Byte k is on the bus during the cycle after edge E(k+1).
  - FIN follows edge E(N+1); IDLE follows E(N+2).
  - Word store: busy for 5 cycles, `done_o` in the 6th.
  - Byte store: busy for 2 cycles.
- Each grant-low edge in WR adds exactly one cycle.

## Configuration
- `STORE_BUF_ARB_EN` defined: arbitration handshake as above.
- Not defined:
  - `bus_grant_i` is ignored and treated as constant 1.
  - `bus_req_o` is tied to 0.
  - Latency is the continuous-grant figure.

## Test plan
- Word store, addr 0x00000100, data 0xDEADBEEF, grant high → writes 0x100=EF, 0x101=BE, 0x102=AD, 0x103=DE on 4 consecutive cycles; `done_o` 1 cycle later.
- Byte store, addr 0x2345, data 0x000000A5 → a single write 0x2345=A5; `busy_o` high for 2 cycles.
- Half store, addr 0x1FFFF, data 0x00001234 → writes 0x1FFFF=34, then 0x00000=12.
- Word store with grant low for 2 edges after byte 1 → `mem_wr_o` low for 2 cycles; bytes 2–3 written afterward with the correct addresses; total busy is 7 cycles.
- Assert `rst` while byte 2 of a word store is on the bus → all outputs 0 asynchronously; no further writes; a new request after reset completes normally.
- `STORE_BUF_ARB_EN` undefined with `bus_grant_i` held 0 → the word store still completes in 5 busy cycles, with `bus_req_o` = 0 throughout.
